ecp5pll_phase_ctrl: RTL and testbench
=====================================

// Module: ecp5pll_phase_ctrl
// PURPOSE
//  Multi-channel dynamic phase controller for the ECP5 EHXPLLL PHASESEL/PHASEDIR/PHASESTEP/PHASELOADREG inputs.
//  Serves debounced inc/dec/select buttons and an absolute-target command port (valid/ready).
//  Sequences the PLL pins with programmable setup/pulse/gap timing; keeps a per-channel phase counter for display/software.
// PARAMETERS
//  C_CHANNELS       4   PLL outputs under control, 1..4 (maps to phasesel 0..C_CHANNELS-1)
//  C_PHASE_BITS     8   phase counter width W; counters wrap modulo 2^W
//  C_DEBOUNCE_BITS 16   debounce counter width; stable time = 2^(C_DEBOUNCE_BITS-1) clk
//  C_SETUP_CYCLES   2   phasesel/phasedir stable before phasestep rises, >=1
//  C_PULSE_CYCLES   2   phasestep / phaseloadreg high time, >=1
//  C_GAP_CYCLES     4   phasestep low time after each pulse, >=1
// PORTS
//  clk           in   1             single clock, 1-100 MHz
//  rstn          in   1             async reset, active low
//  btn_inc       in   1             raw button: step selected channel +1
//  btn_dec       in   1             raw button: step selected channel -1
//  btn_sel       in   1             raw button: advance selected channel
//  cmd_valid     in   1             command request
//  cmd_ready     out  1             command accepted when valid&ready
//  cmd_load      in   1             1: PHASELOADREG pulse; 0: go to cmd_phase
//  cmd_chan      in   2             target channel
//  cmd_phase     in   W             absolute target phase
//  phasesel      out  2             to EHXPLLL PHASESEL
//  phasedir      out  1             to PHASEDIR, 1=up
//  phasestep     out  1             to PHASESTEP, active-high pulse
//  phaseloadreg  out  1             to PHASELOADREG, active-high pulse
//  sel_chan      out  2             button-selected channel
//  phase         out  C_CHANNELS*W  packed counters, ch k at [k*W +: W]
//  busy          out  1             FSM not IDLE
// BEHAVIOUR
//  Reset (async, rstn=0): all outputs 0, counters 0, sel_chan 0, FSM IDLE, debouncers cleared; cmd_ready 1 from first clk after release.
//  Reset mid-pulse drops phasestep/phaseloadreg immediately; PLL phase is NOT restored; software reissues a load.
//  Debounce per button: counter cleared on any sampled input change; once MSB set, input copied to stable value.
//  Press event = 1-cycle rising edge of stable value. inc and dec events same cycle -> both ignored.
//  sel event: sel_chan+1, C_CHANNELS-1 wraps to 0; accepted in any state, affects next step only.
//  inc/dec event in IDLE -> one step on sel_chan. Event while busy is discarded (not queued).
//  cmd_ready = (state==IDLE). cmd accept beats same-cycle button event; button event then discarded.
//  FSM: IDLE -> SETUP(C_SETUP) -> PULSE(C_PULSE) -> GAP(C_GAP) -> SETUP if steps remain else IDLE.
//  Load: IDLE -> LOAD(C_PULSE, phaseloadreg=1) -> GAP -> IDLE; channel counter cleared to 0 entering LOAD.
//  On accept edge: phasesel<=chan, phasedir<=dir, remaining<=count; held constant through whole sequence.
//  Absolute target: d=(cmd_phase-phase[ch]) mod 2^W. d==0 -> accepted, no pulses, back in IDLE next cycle.
//   d<2^(W-1): d up-steps; d>2^(W-1): 2^W-d down-steps; d==2^(W-1): up (tie rule).
//  Counter +/-1 (mod 2^W) at edge entering PULSE; remaining decremented same edge.
//  Per step S+P+G cycles; accept->first phasestep rise = C_SETUP cycles; busy=0 the cycle FSM enters IDLE.
//  Re-SETUP between steps lasts C_SETUP; phasedir never changes while phasestep=1.
//  cmd_chan>=C_CHANNELS: accepted, dropped, no pin activity. phasesel idles at last-used value.
// TESTING (defaults; C_DEBOUNCE_BITS=4 in bench)
//  cmd chan1 phase 3 from 0 -> phasesel=1, phasedir=1, 3 pulses 2 clk wide, 4 clk gaps; phase[1]=3; busy 24 clk.
//  cmd chan0 phase 250 from 0 -> 6 down pulses, phase[0]=250; then phase 122 -> 128 up (tie), phase[0]=122.
//  btn_sel x2 then btn_inc held 20 clk with 3-clk bounce at start -> sel_chan=2, exactly one up pulse, phase[2]=1.
//  btn_inc and btn_dec same cycle -> no pulse; btn_inc during active cmd -> discarded, counts unchanged.
//  cmd_load chan3 with phase[3]=5 -> phaseloadreg high 2 clk, phasestep stays 0, phase[3]=0, cmd_ready after 6 clk.
//  rstn low during PULSE of 4-step cmd -> phasestep 0 same time, all counters 0, cmd_ready=1 clk after release.

Source files
------------

// File: rtl/ecp5pll_phase_ctrl.sv
// Dynamic phase sequencer for ECP5 EHXPLLL: debounced buttons plus an absolute-target command port.
// Latency: accept -> first phasestep rise = C_SETUP_CYCLES clk; each step costs SETUP+PULSE+GAP clk.
// Backpressure: cmd_ready only in IDLE; button steps arriving while busy are dropped, never queued.
module ecp5pll_phase_ctrl #(
    parameter int C_CHANNELS      = 4,
    parameter int C_PHASE_BITS    = 8,
    parameter int C_DEBOUNCE_BITS = 16,
    parameter int C_SETUP_CYCLES  = 2,
    parameter int C_PULSE_CYCLES  = 2,
    parameter int C_GAP_CYCLES    = 4
) (
    input  logic                               clk,
    input  logic                               rstn,
    input  logic                               btn_inc,
    input  logic                               btn_dec,
    input  logic                               btn_sel,
    input  logic                               cmd_valid,
    output logic                               cmd_ready,
    input  logic                               cmd_load,
    input  logic [1:0]                         cmd_chan,
    input  logic [C_PHASE_BITS-1:0]            cmd_phase,
    output logic [1:0]                         phasesel,
    output logic                               phasedir,
    output logic                               phasestep,
    output logic                               phaseloadreg,
    output logic [1:0]                         sel_chan,
    output logic [C_CHANNELS*C_PHASE_BITS-1:0] phase,
    output logic                               busy
);

    localparam int W    = C_PHASE_BITS;
    localparam int DB   = C_DEBOUNCE_BITS;
    localparam int TMAX = (C_SETUP_CYCLES > C_PULSE_CYCLES)
                        ? ((C_SETUP_CYCLES > C_GAP_CYCLES) ? C_SETUP_CYCLES : C_GAP_CYCLES)
                        : ((C_PULSE_CYCLES > C_GAP_CYCLES) ? C_PULSE_CYCLES : C_GAP_CYCLES);
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX + 1) : 1;

    localparam logic [TW-1:0] T_SETUP   = TW'(C_SETUP_CYCLES - 1);
    localparam logic [TW-1:0] T_PULSE   = TW'(C_PULSE_CYCLES - 1);
    localparam logic [TW-1:0] T_GAP     = TW'(C_GAP_CYCLES - 1);
    localparam logic [W-1:0]  HALF      = {1'b1, {(W-1){1'b0}}};
    localparam logic [3:0]    CHAN_MASK = 4'((5'd1 << C_CHANNELS) - 5'd1);
    localparam logic [1:0]    LAST_CHAN = 2'(C_CHANNELS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_GAP,
        S_LOAD
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   tmr_q, tmr_d;
    logic [W-1:0]    rem_q;
    logic [W-1:0]    cnt_q [4];
    logic [1:0]      phasesel_q, sel_chan_q;
    logic            phasedir_q, en_q;

    // Debouncers, bit order {sel, dec, inc}
    logic [2:0]      btn_raw, smp_q, stb_q, stb_prev_q, ev;
    logic [DB-1:0]   db_cnt_q [3];

    assign btn_raw = {btn_sel, btn_dec, btn_inc};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            smp_q      <= '0;
            stb_q      <= '0;
            stb_prev_q <= '0;
            for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
        end else begin
            smp_q      <= btn_raw;
            stb_prev_q <= stb_q;
            for (int i = 0; i < 3; i++) begin
                if (btn_raw[i] != smp_q[i])
                    db_cnt_q[i] <= '0;
                else if (!db_cnt_q[i][DB-1])
                    db_cnt_q[i] <= db_cnt_q[i] + DB'(1);
                if (db_cnt_q[i][DB-1])
                    stb_q[i] <= smp_q[i];
            end
        end
    end

    assign ev = stb_q & ~stb_prev_q;

    logic inc_ev, dec_ev, sel_ev;
    assign inc_ev = ev[0] & ~ev[1];
    assign dec_ev = ev[1] & ~ev[0];
    assign sel_ev = ev[2];

    // Shortest-path step count; the exact half-turn goes up
    logic         cmd_fire, chan_ok, cmd_up;
    logic [W-1:0] diff, cmd_steps;

    assign cmd_ready = (state_q == S_IDLE) && en_q;
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign chan_ok   = CHAN_MASK[cmd_chan];
    assign diff      = cmd_phase - cnt_q[cmd_chan];
    assign cmd_up    = !diff[W-1] || (diff == HALF);
    assign cmd_steps = cmd_up ? diff : (W'(0) - diff);

    logic         seq_start, seq_load, seq_dir, step_now;
    logic [1:0]   seq_chan;
    logic [W-1:0] seq_cnt;

    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        seq_start = 1'b0;
        seq_load  = 1'b0;
        seq_chan  = phasesel_q;
        seq_dir   = phasedir_q;
        seq_cnt   = rem_q;
        step_now  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_fire) begin
                    if (chan_ok && cmd_load) begin
                        state_d   = S_LOAD;
                        tmr_d     = T_PULSE;
                        seq_start = 1'b1;
                        seq_load  = 1'b1;
                        seq_chan  = cmd_chan;
                        seq_cnt   = '0;
                    end else if (chan_ok && (diff != '0)) begin
                        state_d   = S_SETUP;
                        tmr_d     = T_SETUP;
                        seq_start = 1'b1;
                        seq_chan  = cmd_chan;
                        seq_dir   = cmd_up;
                        seq_cnt   = cmd_steps;
                    end
                end else if (inc_ev || dec_ev) begin
                    state_d   = S_SETUP;
                    tmr_d     = T_SETUP;
                    seq_start = 1'b1;
                    seq_chan  = sel_chan_q;
                    seq_dir   = inc_ev;
                    seq_cnt   = W'(1);
                end
            end
            S_SETUP: begin
                if (tmr_q == '0) begin
                    state_d  = S_PULSE;
                    tmr_d    = T_PULSE;
                    step_now = 1'b1;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            S_PULSE, S_LOAD: begin
                if (tmr_q == '0) begin
                    state_d = S_GAP;
                    tmr_d   = T_GAP;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            S_GAP: begin
                if (tmr_q == '0) begin
                    state_d = (rem_q != '0) ? S_SETUP : S_IDLE;
                    tmr_d   = T_SETUP;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                tmr_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            tmr_q   <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
        end
    end

    // Pin config is latched on accept and held for the whole sequence
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            en_q       <= 1'b0;
            rem_q      <= '0;
            phasesel_q <= '0;
            phasedir_q <= 1'b0;
            sel_chan_q <= '0;
            for (int k = 0; k < 4; k++) cnt_q[k] <= '0;
        end else begin
            en_q <= 1'b1;
            if (seq_start) begin
                phasesel_q <= seq_chan;
                phasedir_q <= seq_dir;
                rem_q      <= seq_cnt;
                if (seq_load) cnt_q[seq_chan] <= '0;
            end
            if (step_now) begin
                rem_q             <= rem_q - W'(1);
                cnt_q[phasesel_q] <= phasedir_q ? (cnt_q[phasesel_q] + W'(1))
                                                : (cnt_q[phasesel_q] - W'(1));
            end
            if (sel_ev)
                sel_chan_q <= (sel_chan_q == LAST_CHAN) ? 2'd0 : (sel_chan_q + 2'd1);
        end
    end

    assign phasesel     = phasesel_q;
    assign phasedir     = phasedir_q;
    assign phasestep    = (state_q == S_PULSE);
    assign phaseloadreg = (state_q == S_LOAD);
    assign busy         = (state_q != S_IDLE);
    assign sel_chan     = sel_chan_q;

    for (genvar k = 0; k < C_CHANNELS; k++) begin : g_phase
        assign phase[k*W +: W] = cnt_q[k];
    end

endmodule

// File: tb/tb_ecp5pll_phase_ctrl.sv
// Bench for ecp5pll_phase_ctrl: command vector table with scoreboard, plus button and reset sequences.
module tb_ecp5pll_phase_ctrl;

    localparam int W     = 8;
    localparam int NCH   = 4;
    localparam int SETUP = 2;
    localparam int PULSE = 2;
    localparam int GAP   = 4;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             btn_inc = 1'b0, btn_dec = 1'b0, btn_sel = 1'b0;
    logic             cmd_valid = 1'b0, cmd_load = 1'b0;
    logic [1:0]       cmd_chan = '0;
    logic [W-1:0]     cmd_phase = '0;
    logic             cmd_ready, phasedir, phasestep, phaseloadreg, busy;
    logic [1:0]       phasesel, sel_chan;
    logic [NCH*W-1:0] phase;

    ecp5pll_phase_ctrl #(
        .C_CHANNELS(NCH), .C_PHASE_BITS(W), .C_DEBOUNCE_BITS(4),
        .C_SETUP_CYCLES(SETUP), .C_PULSE_CYCLES(PULSE), .C_GAP_CYCLES(GAP)
    ) dut (
        .clk(clk), .rstn(rstn),
        .btn_inc(btn_inc), .btn_dec(btn_dec), .btn_sel(btn_sel),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_load(cmd_load),
        .cmd_chan(cmd_chan), .cmd_phase(cmd_phase),
        .phasesel(phasesel), .phasedir(phasedir), .phasestep(phasestep),
        .phaseloadreg(phaseloadreg), .sel_chan(sel_chan), .phase(phase), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Pin monitor: statistics restart whenever mon_gen is bumped
    int   mon_gen = 0, seen_gen = 0;
    int   mon_rise = 0, mon_hi_step = 0, mon_hi_load = 0, mon_busy = 0;
    int   mon_cyc = 0, mon_lat = -1, mon_bad = 0;
    logic mon_dir = 1'b0, prev_step = 1'b0, prev_load = 1'b0, prev_dir = 1'b0;
    logic [1:0] mon_sel = '0;

    always @(negedge clk) begin
        if (mon_gen != seen_gen) begin
            seen_gen = mon_gen;
            mon_rise = 0; mon_hi_step = 0; mon_hi_load = 0; mon_busy = 0;
            mon_cyc = 0; mon_lat = -1; mon_bad = 0;
        end
        if ((phasestep && !prev_step) || (phaseloadreg && !prev_load)) begin
            if (mon_lat < 0) begin
                mon_lat = mon_cyc;
                mon_dir = phasedir;
                mon_sel = phasesel;
            end else if (phasedir != mon_dir || phasesel != mon_sel) begin
                mon_bad++;
            end
        end
        if (phasestep && prev_step && phasedir != prev_dir) mon_bad++;
        if (phasestep && !prev_step) mon_rise++;
        if (phasestep) mon_hi_step++;
        if (phaseloadreg) mon_hi_load++;
        if (busy) mon_busy++;
        mon_cyc++;
        prev_step = phasestep;
        prev_load = phaseloadreg;
        prev_dir  = phasedir;
    end

    function automatic int ph(input int c);
        return int'(phase[c*W +: W]);
    endfunction

    task automatic start_cmd(input logic load, input int chan, input int tgt);
        @(negedge clk);
        chk("ready_before_cmd", int'(cmd_ready), 1);
        cmd_valid = 1'b1;
        cmd_load  = load;
        cmd_chan  = 2'(chan);
        cmd_phase = W'(tgt);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        mon_gen++;
    endtask

    task automatic wait_idle(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!busy) begin
                done = 1'b1;
                break;
            end
        end
        #1;
        if (!done) chk({name, "_timeout"}, 0, 1);
    endtask

    task automatic hold_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    typedef struct {
        bit load;
        int chan;
        int tgt;
        int dir;
        int pulses;
        int phase;
        int lat;
        int load_hi;
    } vec_t;

    vec_t vecs[9];
    vec_t sb[$];

    initial begin
        vec_t e;
        int   exp_busy;

        //          load chan tgt  dir pulses phase lat load_hi
        vecs[0] = '{0,   1,   3,   1,  3,     3,    2,  0};
        vecs[1] = '{0,   0,   250, 0,  6,     250,  2,  0};
        vecs[2] = '{0,   0,   122, 1,  128,   122,  2,  0};
        vecs[3] = '{0,   1,   3,   0,  0,     3,    -1, 0};
        vecs[4] = '{0,   3,   5,   1,  5,     5,    2,  0};
        vecs[5] = '{1,   3,   0,   0,  0,     0,    0,  2};
        vecs[6] = '{0,   1,   2,   0,  1,     2,    2,  0};
        vecs[7] = '{0,   3,   255, 0,  1,     255,  2,  0};
        vecs[8] = '{0,   3,   1,   1,  2,     1,    2,  0};

        // Reset state
        #2;
        chk("rst_ready", int'(cmd_ready), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_pins", int'({phasestep, phaseloadreg, phasedir, phasesel}), 0);
        chk("rst_sel_chan", int'(sel_chan), 0);
        chk("rst_phase", int'(phase), 0);
        hold_cycles(3);
        rstn = 1'b1;
        #1;
        chk("ready_before_first_clk", int'(cmd_ready), 0);
        @(negedge clk);
        chk("ready_after_first_clk", int'(cmd_ready), 1);

        // Command table through the scoreboard
        for (int i = 0; i < 9; i++) begin
            sb.push_back(vecs[i]);
            start_cmd(vecs[i].load, vecs[i].chan, vecs[i].tgt);
            wait_idle($sformatf("v%0d", i));
            e = sb.pop_front();
            exp_busy = e.load ? (PULSE + GAP) : e.pulses * (SETUP + PULSE + GAP);
            chk($sformatf("v%0d_pulses", i), mon_rise, e.pulses);
            chk($sformatf("v%0d_step_hi", i), mon_hi_step, e.pulses * PULSE);
            chk($sformatf("v%0d_load_hi", i), mon_hi_load, e.load_hi);
            chk($sformatf("v%0d_busy", i), mon_busy, exp_busy);
            chk($sformatf("v%0d_phase", i), ph(e.chan), e.phase);
            chk($sformatf("v%0d_latency", i), mon_lat, e.lat);
            chk($sformatf("v%0d_dir_stable", i), mon_bad, 0);
            chk($sformatf("v%0d_ready_after", i), int'(cmd_ready), 1);
            if (e.lat >= 0) chk($sformatf("v%0d_phasesel", i), int'(mon_sel), e.chan);
            if (e.pulses > 0) chk($sformatf("v%0d_dir", i), int'(mon_dir), e.dir);
        end

        // Two select presses
        for (int p = 0; p < 2; p++) begin
            @(negedge clk); btn_sel = 1'b1;
            hold_cycles(14);
            btn_sel = 1'b0;
            hold_cycles(14);
        end
        chk("sel_chan_after_2", int'(sel_chan), 2);

        // Bouncy inc press on channel 2
        @(negedge clk); mon_gen++;
        btn_inc = 1'b1; @(negedge clk);
        btn_inc = 1'b0; @(negedge clk);
        btn_inc = 1'b1;
        hold_cycles(20);
        btn_inc = 1'b0;
        hold_cycles(40);
        chk("btn_inc_pulses", mon_rise, 1);
        chk("btn_inc_dir", int'(mon_dir), 1);
        chk("btn_inc_sel", int'(mon_sel), 2);
        chk("btn_inc_phase2", ph(2), 1);

        // inc and dec together cancel
        @(negedge clk); mon_gen++;
        btn_inc = 1'b1; btn_dec = 1'b1;
        hold_cycles(14);
        btn_inc = 1'b0; btn_dec = 1'b0;
        hold_cycles(30);
        chk("both_btn_pulses", mon_rise, 0);
        chk("both_btn_phase2", ph(2), 1);

        // inc while a 6-step command runs is dropped
        start_cmd(1'b0, 1, 8);
        @(negedge clk);
        chk("ready_while_busy", int'(cmd_ready), 0);
        btn_inc = 1'b1;
        hold_cycles(14);
        btn_inc = 1'b0;
        wait_idle("busy_btn");
        hold_cycles(20);
        chk("busy_btn_pulses", mon_rise, 6);
        chk("busy_btn_phase1", ph(1), 8);
        chk("busy_btn_phase2", ph(2), 1);

        // Reset during a pulse of a 4-step command
        start_cmd(1'b0, 0, 126);
        begin
            bit hit = 1'b0;
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                if (phasestep) begin
                    hit = 1'b1;
                    break;
                end
            end
            chk("reached_pulse", int'(hit), 1);
        end
        rstn = 1'b0;
        #1;
        chk("midrst_step", int'(phasestep), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_phase", int'(phase), 0);
        chk("midrst_ready", int'(cmd_ready), 0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("midrst_ready_after", int'(cmd_ready), 1);
        chk("midrst_step_after", int'(phasestep), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
